// File: rtl/axindemux_if.sv
// AXIN packet-stream bundle for the demux: one input stream and NOUT output streams.
// The slave modport is the demux's view; the master modport is the surrounding fabric's view.
interface axindemux_if #(
    parameter int NOUT  = 4,
    parameter int DW    = 64,
    parameter int WBITS = $clog2(DW/8)
) ();
    logic                    S_VALID;
    logic                    S_READY;
    logic [DW-1:0]           S_DATA;
    logic [WBITS-1:0]        S_BYTES;
    logic                    S_LAST;
    logic                    S_ABORT;
    logic [NOUT-1:0]         S_ROUTE;

    logic [NOUT-1:0]         M_VALID;
    logic [NOUT-1:0]         M_READY;
    logic [NOUT*DW-1:0]      M_DATA;
    logic [NOUT*WBITS-1:0]   M_BYTES;
    logic [NOUT-1:0]         M_LAST;
    logic [NOUT-1:0]         M_ABORT;

    modport slave (
        input  S_VALID, S_DATA, S_BYTES, S_LAST, S_ABORT, S_ROUTE,
        output S_READY,
        output M_VALID, M_DATA, M_BYTES, M_LAST, M_ABORT,
        input  M_READY
    );

    modport master (
        output S_VALID, S_DATA, S_BYTES, S_LAST, S_ABORT, S_ROUTE,
        input  S_READY,
        input  M_VALID, M_DATA, M_BYTES, M_LAST, M_ABORT,
        output M_READY
    );
endinterface

// File: rtl/axindemux.sv
// Routes one AXIN packet stream to any subset of NOUT output streams, chosen per packet
// by the S_ROUTE mask on the first beat; packets with an empty mask are dropped and counted.
//
// state | meaning
// IDLE  | waiting for a packet's first beat; S_ROUTE is sampled here
// FWD   | mid-packet, beats broadcast to the latched route
// DROP  | mid-packet with an empty route, beats swallowed until S_LAST
module axindemux #(
    parameter int NOUT         = 4,
    parameter int DW           = 64,
    parameter int WBITS        = $clog2(DW/8),
    parameter bit OPT_LOWPOWER = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    axindemux_if.slave  bus,
    output logic [15:0] o_drops
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FWD  = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    logic [1:0]       state_q;
    logic [NOUT-1:0]  route_q;
    logic [15:0]      drops_q;

    logic [NOUT-1:0]  mvalid_q;
    logic [NOUT-1:0]  mlast_q;
    logic [NOUT-1:0]  mabort_q;
    logic [DW-1:0]    mdata_q  [NOUT];
    logic [WBITS-1:0] mbytes_q [NOUT];

    logic [NOUT-1:0]        sel_d;
    logic [NOUT-1:0]        port_free_d;
    logic                   s_ready_d;
    logic                   take_beat_d;
    logic                   abort_fwd_d;
    logic                   drop_first_d;
    logic [NOUT*DW-1:0]     m_data_d;
    logic [NOUT*WBITS-1:0]  m_bytes_d;

    // A first beat is steered by the live S_ROUTE; later beats by the latched route.
    always_comb begin
        sel_d        = (state_q == IDLE) ? bus.S_ROUTE : route_q;
        port_free_d  = ~mvalid_q | bus.M_READY;
        s_ready_d    = (state_q == DROP) ? 1'b1 : &(port_free_d | ~sel_d);
        take_beat_d  = bus.S_VALID && s_ready_d && !bus.S_ABORT
                       && (state_q != DROP) && (sel_d != '0);
        abort_fwd_d  = (state_q == FWD) && bus.S_ABORT;
        drop_first_d = (state_q == IDLE) && bus.S_VALID && !bus.S_ABORT
                       && (bus.S_ROUTE == '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            route_q <= '0;
            drops_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (drop_first_d) begin
                        if (drops_q != 16'hffff)
                            drops_q <= drops_q + 16'd1;
                        if (!bus.S_LAST)
                            state_q <= DROP;
                    end else if (take_beat_d) begin
                        route_q <= bus.S_ROUTE;
                        if (!bus.S_LAST)
                            state_q <= FWD;
                    end
                end
                FWD: begin
                    if (abort_fwd_d || (take_beat_d && bus.S_LAST))
                        state_q <= IDLE;
                end
                DROP: begin
                    if (bus.S_ABORT || (bus.S_VALID && bus.S_LAST))
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A port only loads when it is free, since S_READY already waited for every selected port.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < NOUT; k++) begin
            if (i_reset) begin
                mvalid_q[k] <= 1'b0;
                mabort_q[k] <= 1'b0;
                if (OPT_LOWPOWER) begin
                    mdata_q[k]  <= '0;
                    mbytes_q[k] <= '0;
                    mlast_q[k]  <= 1'b0;
                end
            end else begin
                if (take_beat_d && sel_d[k]) begin
                    mvalid_q[k] <= 1'b1;
                    mdata_q[k]  <= bus.S_DATA;
                    mbytes_q[k] <= bus.S_BYTES;
                    mlast_q[k]  <= bus.S_LAST;
                end else if (port_free_d[k]) begin
                    mvalid_q[k] <= 1'b0;
                    if (OPT_LOWPOWER) begin
                        mdata_q[k]  <= '0;
                        mbytes_q[k] <= '0;
                        mlast_q[k]  <= 1'b0;
                    end
                end
                // Every routed port already holds the packet's first beat once in FWD.
                mabort_q[k] <= (abort_fwd_d && route_q[k])
                               || (mabort_q[k] && !port_free_d[k]);
            end
        end
    end

    always_comb begin
        m_data_d  = '0;
        m_bytes_d = '0;
        for (int k = 0; k < NOUT; k++) begin
            m_data_d[k*DW +: DW]        = mdata_q[k];
            m_bytes_d[k*WBITS +: WBITS] = mbytes_q[k];
        end
    end

    assign bus.S_READY = s_ready_d;
    assign bus.M_VALID = mvalid_q;
    assign bus.M_DATA  = m_data_d;
    assign bus.M_BYTES = m_bytes_d;
    assign bus.M_LAST  = mlast_q;
    assign bus.M_ABORT = mabort_q;
    assign o_drops     = drops_q;
endmodule

// File: tb/tb_axindemux.sv
// Directed bench for axindemux: a driver pushes expected beats per port into queues and a
// monitor pops and compares every beat the DUT hands off on each output port.
module tb_axindemux;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] drops;

    axindemux_if #(.NOUT(4), .DW(64), .WBITS(3)) ifc ();

    axindemux #(.NOUT(4), .DW(64), .WBITS(3), .OPT_LOWPOWER(1'b0)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (ifc),
        .o_drops (drops)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [67:0] q0[$], q1[$], q2[$], q3[$];

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int k, input logic [67:0] v);
        case (k)
            0: q0.push_back(v);
            1: q1.push_back(v);
            2: q2.push_back(v);
            default: q3.push_back(v);
        endcase
    endtask

    // Monitor: a beat transfers at the posedge following a negedge with VALID && READY.
    initial begin
        logic [67:0] got, ev;
        int sz;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (ifc.M_VALID[k] && ifc.M_READY[k]) begin
                    got = {ifc.M_LAST[k], ifc.M_BYTES[k*3 +: 3], ifc.M_DATA[k*64 +: 64]};
                    case (k)
                        0: sz = q0.size();
                        1: sz = q1.size();
                        2: sz = q2.size();
                        default: sz = q3.size();
                    endcase
                    if (sz == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_beat_p%0d: got %0h, expected no beat", k, got);
                    end else begin
                        case (k)
                            0: ev = q0.pop_front();
                            1: ev = q1.pop_front();
                            2: ev = q2.pop_front();
                            default: ev = q3.pop_front();
                        endcase
                        chk($sformatf("beat_p%0d", k), got, ev);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        ifc.S_VALID = 1'b0;
        ifc.S_ABORT = 1'b0;
        ifc.S_LAST  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one beat until accepted; exp marks the ports that must emit it.
    task automatic beat(input logic [63:0] d, input logic [2:0] b, input logic l,
                        input logic [3:0] r, input logic [3:0] exp,
                        input bit cm, input logic [3:0] emv, output int stalls);
        stalls = 0;
        ifc.S_VALID = 1'b1;
        ifc.S_ABORT = 1'b0;
        ifc.S_DATA  = d;
        ifc.S_BYTES = b;
        ifc.S_LAST  = l;
        ifc.S_ROUTE = r;
        @(negedge clk);
        if (cm) chk("m_valid_latency", {64'd0, ifc.M_VALID}, {64'd0, emv});
        while (!ifc.S_READY) begin
            stalls++;
            if (stalls > 50) begin
                chk("accept_timeout", 68'd0, 68'd1);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        for (int k = 0; k < 4; k++)
            if (exp[k]) push_exp(k, {l, b, d});
        #1;
    endtask

    initial begin
        int st;
        rst         = 1'b1;
        ifc.S_VALID = 1'b0;
        ifc.S_DATA  = '0;
        ifc.S_BYTES = '0;
        ifc.S_LAST  = 1'b0;
        ifc.S_ABORT = 1'b0;
        ifc.S_ROUTE = '0;
        ifc.M_READY = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", {64'd0, ifc.M_VALID}, 68'd0);
        chk("rst_m_abort", {64'd0, ifc.M_ABORT}, 68'd0);
        chk("rst_drops",   {52'd0, drops},       68'd0);
        rst = 1'b0;
        idle(1);
        chk("idle_s_ready", {67'd0, ifc.S_READY}, 68'd1);

        // 3-beat packet to port 1 only, one cycle latency, LAST on beat 3
        beat(64'h1111_0000_0000_0001, 3'd7, 1'b0, 4'b0010, 4'b0010, 1'b1, 4'b0000, st);
        beat(64'h1111_0000_0000_0002, 3'd7, 1'b0, 4'b0010, 4'b0010, 1'b1, 4'b0010, st);
        beat(64'h1111_0000_0000_0003, 3'd2, 1'b1, 4'b0010, 4'b0010, 1'b1, 4'b0010, st);
        ifc.S_VALID = 1'b0;
        @(negedge clk);
        chk("p1_last_beat3", {60'd0, ifc.M_LAST & ifc.M_VALID, ifc.M_VALID}, {60'd0, 4'b0010, 4'b0010});
        @(posedge clk); #1;
        @(negedge clk);
        chk("p1_drained", {64'd0, ifc.M_VALID}, 68'd0);
        idle(1);

        // broadcast to ports 0 and 2 with port 2 stalled for 5 cycles
        beat(64'h2222_0000_0000_0001, 3'd0, 1'b0, 4'b0101, 4'b0101, 1'b0, 4'b0000, st);
        ifc.M_READY = 4'b1011;
        ifc.S_DATA  = 64'h2222_0000_0000_0002;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bcast_stall_s_ready", {67'd0, ifc.S_READY}, 68'd0);
            @(posedge clk); #1;
        end
        ifc.M_READY = 4'b1111;
        beat(64'h2222_0000_0000_0002, 3'd1, 1'b0, 4'b0101, 4'b0101, 1'b0, 4'b0000, st);
        chk("bcast_resume_stalls", 68'(st), 68'd0);
        beat(64'h2222_0000_0000_0003, 3'd4, 1'b1, 4'b0101, 4'b0101, 1'b0, 4'b0000, st);
        idle(3);

        // empty route: 4 beats swallowed, never stalled, one drop counted on the first beat
        chk("drops_before", {52'd0, drops}, 68'd0);
        beat(64'h3333_0000_0000_0001, 3'd0, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, st);
        chk("drop_stall_b1", 68'(st), 68'd0);
        chk("drops_first_beat", {52'd0, drops}, 68'd1);
        beat(64'h3333_0000_0000_0002, 3'd0, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, st);
        chk("drop_stall_b2", 68'(st), 68'd0);
        beat(64'h3333_0000_0000_0003, 3'd0, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, st);
        chk("drop_stall_b3", 68'(st), 68'd0);
        beat(64'h3333_0000_0000_0004, 3'd0, 1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, st);
        chk("drop_stall_b4", 68'(st), 68'd0);
        idle(1);
        chk("drops_after", {52'd0, drops}, 68'd1);
        chk("drop_no_valid", {64'd0, ifc.M_VALID}, 68'd0);

        // abort on beat 2 of a packet routed to port 3
        beat(64'h4444_0000_0000_0001, 3'd5, 1'b0, 4'b1000, 4'b1000, 1'b0, 4'b0000, st);
        ifc.S_VALID = 1'b1;
        ifc.S_DATA  = 64'h4444_0000_0000_0002;
        ifc.S_ABORT = 1'b1;
        @(posedge clk); #1;
        ifc.S_ABORT = 1'b0;
        ifc.S_VALID = 1'b0;
        chk("abort_m_abort", {64'd0, ifc.M_ABORT}, {64'd0, 4'b1000});
        chk("abort_no_beat", {64'd0, ifc.M_VALID}, 68'd0);
        @(posedge clk); #1;
        chk("abort_cleared", {64'd0, ifc.M_ABORT}, 68'd0);
        beat(64'h4444_0000_0000_0011, 3'd3, 1'b0, 4'b0001, 4'b0001, 1'b0, 4'b0000, st);
        beat(64'h4444_0000_0000_0012, 3'd6, 1'b1, 4'b0001, 4'b0001, 1'b0, 4'b0000, st);
        idle(2);
        chk("abort_after_clean", {64'd0, ifc.M_ABORT}, 68'd0);

        // back-to-back single-beat packets, no bubble on S_READY
        beat(64'h5555_0000_0000_0001, 3'd1, 1'b1, 4'b0001, 4'b0001, 1'b1, 4'b0000, st);
        chk("b2b_stall_1", 68'(st), 68'd0);
        beat(64'h5555_0000_0000_0002, 3'd2, 1'b1, 4'b0010, 4'b0010, 1'b1, 4'b0001, st);
        chk("b2b_stall_2", 68'(st), 68'd0);
        ifc.S_VALID = 1'b0;
        @(negedge clk);
        chk("b2b_second_last", {60'd0, ifc.M_LAST & ifc.M_VALID, ifc.M_VALID}, {60'd0, 4'b0010, 4'b0010});
        idle(2);

        // reset while forwarding
        beat(64'h6666_0000_0000_0001, 3'd0, 1'b0, 4'b0100, 4'b0100, 1'b0, 4'b0000, st);
        ifc.M_READY = 4'b1011;
        ifc.S_VALID = 1'b1;
        ifc.S_DATA  = 64'h6666_0000_0000_0002;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_m_valid", {64'd0, ifc.M_VALID}, 68'd0);
        chk("midrst_m_abort", {64'd0, ifc.M_ABORT}, 68'd0);
        chk("midrst_drops",   {52'd0, drops},       68'd0);
        rst = 1'b0;
        ifc.S_VALID = 1'b0;
        q2.delete();
        ifc.M_READY = 4'b1111;
        idle(1);
        chk("postrst_m_abort", {64'd0, ifc.M_ABORT}, 68'd0);
        beat(64'h6666_0000_0000_0003, 3'd4, 1'b1, 4'b0001, 4'b0001, 1'b0, 4'b0000, st);
        idle(3);

        chk("q0_empty", 68'(q0.size()), 68'd0);
        chk("q1_empty", 68'(q1.size()), 68'd0);
        chk("q2_empty", 68'(q2.size()), 68'd0);
        chk("q3_empty", 68'(q3.size()), 68'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/axindemux.md
AXINDEMUX -- requirements
Module: axindemux

Interface
REQ-001 SHALL have parameter NOUT, default 4: number of outgoing packet ports.
REQ-002 SHALL have parameter DW, default 64: data bits per beat.
REQ-003 SHALL have parameter WBITS, default $clog2(DW/8): width of the BYTES field.
REQ-004 SHALL have parameter OPT_LOWPOWER, default 0: zero M_DATA/M_BYTES/M_LAST on every port whose M_VALID is low.
REQ-005 SHALL have port i_clk, input, 1: sole clock; one clock; reset is synchronous and active-high.
REQ-006 SHALL have port i_reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have ports S_VALID, S_READY, S_DATA[DW], S_BYTES[WBITS], S_LAST, S_ABORT: single incoming AXIN packet stream.
REQ-008 SHALL have port S_ROUTE, input, NOUT: destination mask; sampled only on the first beat of a packet.
REQ-009 SHALL have ports M_VALID[NOUT], M_READY[NOUT], M_DATA[NOUT*DW], M_BYTES[NOUT*WBITS], M_LAST[NOUT], M_ABORT[NOUT]: outgoing AXIN streams.
REQ-010 SHALL have port o_drops, output, 16: count of dropped packets; saturates at 16'hffff.

Function
REQ-011 SHALL implement a state machine with states IDLE, FWD and DROP.
REQ-012 IDLE: a first beat (S_VALID) with S_ROUTE==0 SHALL be accepted at once (S_READY=1) and discarded; state goes to DROP unless S_LAST.
REQ-013 IDLE: a first beat with S_ROUTE!=0 SHALL latch S_ROUTE into the route register; state goes to FWD unless S_LAST.
REQ-014 Multi-hot S_ROUTE SHALL broadcast the packet to every selected port.
REQ-015 S_READY in IDLE/FWD SHALL be the AND over selected ports k of (!M_VALID[k] || M_READY[k]); unselected ports SHALL never stall the input.
REQ-016 An accepted beat SHALL appear on every selected port's M_* registers the next cycle (latency 1); M_VALID[k] SHALL stay high, with data stable, until M_READY[k].
REQ-017 FWD: acceptance with S_LAST SHALL return to IDLE; the route register changes only in IDLE.
REQ-018 DROP: S_READY SHALL be 1; all beats are discarded; S_LAST acceptance returns to IDLE; o_drops SHALL increment once per dropped packet, on its first beat.
REQ-019 S_ABORT in FWD SHALL be accepted regardless of S_READY; it SHALL set M_ABORT[k] for each routed port, then return to IDLE; no data beat is taken that cycle.
REQ-020 M_ABORT[k] SHALL clear on the first cycle with !M_VALID[k] || M_READY[k] and no new abort.
REQ-021 S_ABORT in IDLE or DROP SHALL be accepted and ignored; DROP returns to IDLE.
REQ-022 M_ABORT[k] SHALL NOT be raised for a port that has not yet received a beat of the current packet.
REQ-023 A single-beat packet (first beat with S_LAST) SHALL stay in IDLE and forward or drop normally.

Reset
REQ-024 i_reset SHALL force state IDLE, route=0, M_VALID=0, M_ABORT=0 and o_drops=0 on every port.
REQ-025 M_DATA/M_BYTES/M_LAST SHALL reset to 0 only when OPT_LOWPOWER=1.
REQ-026 A reset mid-packet SHALL discard the packet silently: no M_ABORT and no drop count.

Structure
REQ-027 No shared package SHALL be used; state encodings SHALL be localparams within the module.
REQ-028 No sub-module SHALL be used; the optional input skidbuffer is the existing netskid, instantiated by the parent if required.

Verification
REQ-029 Bench SHALL cover: 3-beat packet, S_ROUTE=4'b0010, all M_READY=1 -> port 1 only emits 3 beats, M_LAST on beat 3, 1-cycle latency.
REQ-030 Bench SHALL cover: S_ROUTE=4'b0101, M_READY[2]=0 for 5 cycles -> S_READY=0 for those cycles, ports 0 and 2 receive identical beats.
REQ-031 Bench SHALL cover: S_ROUTE=0, 4-beat packet -> S_READY=1 throughout, no M_VALID, o_drops 0->1.
REQ-032 Bench SHALL cover: S_ABORT on beat 2 of a packet routed 4'b1000 -> M_ABORT[3]=1 next cycle, state IDLE, next packet forwards cleanly.
REQ-033 Bench SHALL cover: back-to-back single-beat packets routed 0001 then 0010 -> no bubble on S_READY, each port one M_LAST.
REQ-034 Bench SHALL cover: i_reset during FWD -> all M_VALID/M_ABORT=0 next cycle, o_drops=0.
